mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-access stage control between pipeline register PS3 and PS4 (the MEM/WB register).
- Takes the load/store request from PS3 and drives a variable-latency, handshaked data-memory port.
- Generates byte enables and lane-replicated write data; aligns and extends load data.
- Stalls the pipeline until the access completes, then presents load data to PS4's datamem_data_in.

Parameters:
DM_ADDR_BIT, 10, word-address width of data-memory port
ACK_TIMEOUT, 15, max BUSY cycles without mem_ack before bus error (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset
valid  in  1  PS3 holds a live instruction
r_datamem  in  1  load request
w_datamem  in  1  store request
mem_width  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
mem_signed  in  1  1=sign-extend loads, 0=zero-extend
alu_data_res  in  32  byte address
store_data  in  32  rt value for stores
mem_req  out  1  memory request, registered
mem_we  out  1  write strobe, registered
mem_addr  out  DM_ADDR_BIT  alu_data_res[DM_ADDR_BIT+1:2], registered
mem_be  out  4  byte enables, registered
mem_wdata  out  32  lane-replicated store data, registered
mem_ack  in  1  memory completes request this cycle
mem_rdata  in  32  read word, valid with mem_ack
load_data  out  32  aligned/extended load result to PS4
stall  out  1  hold PS1-PS3 and PS4 en
misalign  out  1  misaligned-access pulse, combinational
bus_err  out  1  timeout pulse

Behaviour:
- Reset (async): state IDLE, mem_req/mem_we=0, mem_addr/mem_be/mem_wdata=0, load_data=0, timeout counter=0, bus_err=0.
- access = valid & (r_datamem | w_datamem). Load has priority if both are set; a store is then not performed.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. Then misalign=1 (IDLE only), no request, stall=0, load_data unchanged.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- Write data: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
- Load extract: byte lane addr[1:0] selected from mem_rdata; half lane addr[1]. Sign- or zero-extend to 32 bits per mem_signed.
- State machine: IDLE, BUSY, DONE.
  - IDLE: on an aligned access, stall=1 combinationally. At the clock edge: register mem_addr/be/wdata, set mem_we=w&~r, mem_req=1, counter=0, go BUSY. Otherwise stall=0.
  - BUSY: stall=1; mem_req held 1; all request fields held stable.
  - BUSY, mem_ack=1 at an edge: mem_req/mem_we drop to 0, go DONE. For a load, load_data is registered from the extracted mem_rdata; for a store, load_data is unchanged.
  - BUSY, no ack: counter increments. When counter reaches ACK_TIMEOUT-1 without ack, drop mem_req, load_data=0, bus_err=1 for the DONE cycle, go DONE.
  - DONE: stall=0, so PS4 captures load_data this cycle. Unconditionally go IDLE next edge. A new access is not evaluated in DONE.
- Latency: zero-wait memory (ack in the first BUSY cycle) means 2 stall cycles, with the result in the third cycle.
- mem_ack while not in BUSY is ignored.
- Reset mid-BUSY: the request drops immediately and any late ack is ignored.
- bus_err and ack in the same cycle: ack wins, no error.

Test Plan:
- Word load at 0x0000_0010, ack on the first BUSY cycle, rdata 0xDEADBEEF: mem_addr=4, be=1111, stall high 2 cycles, load_data=0xDEADBEEF in DONE.
- Signed byte load at 0x13, rdata 0x80AA5511: be=1000, load_data=0xFFFFFF80. Same access with mem_signed=0: load_data=0x00000080.
- Half store at 0x22, store_data 0x1234ABCD, ack after 3 cycles: mem_we=1, be=1100, wdata=0xABCDABCD, mem_addr=8, stall held 5 cycles total.
- Word load at 0x06: misalign=1, mem_req never asserts, stall=0.
- No ack for 15 BUSY cycles: mem_req drops, bus_err pulses 1 cycle, load_data=0, returns to IDLE.
- rst_n low during BUSY, then ack arrives: mem_req=0 asynchronously, state stays IDLE, load_data stays 0.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage: turns the PS3 load/store into a handshaked data-memory
// request, stalls the pipeline until it completes and hands aligned load data to PS4.
module mem_access_stage #(
    parameter int DM_ADDR_BIT = 10,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid,
    input  logic                   r_datamem,
    input  logic                   w_datamem,
    input  logic [1:0]             mem_width,
    input  logic                   mem_signed,
    input  logic [31:0]            alu_data_res,
    input  logic [31:0]            store_data,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [DM_ADDR_BIT-1:0] mem_addr,
    output logic [3:0]             mem_be,
    output logic [31:0]            mem_wdata,
    input  logic                   mem_ack,
    input  logic [31:0]            mem_rdata,
    output logic [31:0]            load_data,
    output logic                   stall,
    output logic                   misalign,
    output logic                   bus_err,
    output logic [1:0]             fsm_state
);

    // Memory handshake: mem_req rises with all request fields registered and
    // holds them stable until the cycle mem_ack is seen high; ack is sampled only in BUSY.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             access;
    logic             misaligned;
    logic             start;
    logic             timeout;
    logic [1:0]       lane;
    logic [3:0]       be_next;
    logic [31:0]      wdata_next;

    // Request attributes kept for aligning the returning read word.
    logic [1:0]       req_lane;
    logic [1:0]       req_width;
    logic             req_signed;
    logic             req_load;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      rd_ext;

    logic             unused_addr_bits;
    assign unused_addr_bits = ^alu_data_res[31:DM_ADDR_BIT+2];

    assign access    = valid & (r_datamem | w_datamem);
    assign lane      = alu_data_res[1:0];
    assign fsm_state = state;

    always_comb begin
        misaligned = 1'b0;
        be_next    = 4'b1111;
        wdata_next = store_data;
        case (mem_width)
            2'd0: begin
                be_next    = 4'b0001 << lane;
                wdata_next = {4{store_data[7:0]}};
            end
            2'd1: begin
                misaligned = lane[0];
                be_next    = 4'b0011 << lane;
                wdata_next = {2{store_data[15:0]}};
            end
            default: misaligned = (lane != 2'b00);
        endcase
    end

    assign start   = (state == IDLE) & access & ~misaligned;
    assign timeout = (state == BUSY) & ~mem_ack & (wait_cnt == TO_LAST);

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        misalign   = 1'b0;
        case (state)
            IDLE: begin
                misalign = access & misaligned;
                stall    = start;
                if (start) next_state = BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ack || timeout) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        rd_byte = mem_rdata[7:0];
        case (req_lane)
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            2'd3:    rd_byte = mem_rdata[31:24];
            default: rd_byte = mem_rdata[7:0];
        endcase
        rd_half = req_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (req_width)
            2'd0:    rd_ext = {{24{req_signed & rd_byte[7]}}, rd_byte};
            2'd1:    rd_ext = {{16{req_signed & rd_half[15]}}, rd_half};
            default: rd_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= 4'b0000;
            mem_wdata  <= 32'h0;
            load_data  <= 32'h0;
            wait_cnt   <= '0;
            bus_err    <= 1'b0;
            req_lane   <= 2'b00;
            req_width  <= 2'b00;
            req_signed <= 1'b0;
            req_load   <= 1'b0;
        end else begin
            bus_err <= timeout;
            if (start) begin
                mem_req    <= 1'b1;
                mem_we     <= w_datamem & ~r_datamem;
                mem_addr   <= alu_data_res[DM_ADDR_BIT+1:2];
                mem_be     <= be_next;
                mem_wdata  <= wdata_next;
                wait_cnt   <= '0;
                req_lane   <= lane;
                req_width  <= mem_width;
                req_signed <= mem_signed;
                req_load   <= r_datamem;
            end else if (state == BUSY) begin
                if (mem_ack) begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    if (req_load) load_data <= rd_ext;
                end else if (timeout) begin
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    load_data <= 32'h0;
                end else begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: scripted accesses, a scripted memory
// responder and a result queue checked when the stage reaches DONE.
module tb_mem_access_stage;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        r_datamem = 1'b0;
    logic        w_datamem = 1'b0;
    logic [1:0]  mem_width = 2'd0;
    logic        mem_signed = 1'b0;
    logic [31:0] alu_data_res = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] load_data;
    logic        stall;
    logic        misalign;
    logic        bus_err;
    logic [1:0]  fsm_state;

    int total = 0;
    int bad = 0;
    logic [32:0] exp_q[$];
    logic [31:0] last_load = 32'h0;

    mem_access_stage #(.DM_ADDR_BIT(10), .ACK_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .r_datamem(r_datamem),
        .w_datamem(w_datamem), .mem_width(mem_width), .mem_signed(mem_signed),
        .alu_data_res(alu_data_res), .store_data(store_data), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .load_data(load_data), .stall(stall),
        .misalign(misalign), .bus_err(bus_err), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed=time_limit expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_load(input logic [1:0] width, input logic sgn,
                                               input logic [1:0] a, input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] res;
        res = rd;
        if (width == 2'd0) begin
            sh  = rd >> (8 * a);
            res = sh & 32'h0000_00FF;
            if (sgn && sh[7]) res = res | 32'hFFFF_FF00;
        end else if (width == 2'd1) begin
            sh  = a[1] ? (rd >> 16) : rd;
            res = sh & 32'h0000_FFFF;
            if (sgn && sh[15]) res = res | 32'hFFFF_0000;
        end
        return res;
    endfunction

    // Called just after a rising edge with the stage in IDLE.
    task automatic do_access(input string tag, input logic r, input logic w,
                             input logic [1:0] width, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input int ack_after, input logic [31:0] rdata,
                             input logic [9:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input logic exp_we,
                             input int exp_stall, input logic [32:0] exp_result);
        int   stalls;
        int   busy;
        logic got_done;
        logic [32:0] exp_v;
        exp_q.push_back(exp_result);
        valid = 1'b1; r_datamem = r; w_datamem = w; mem_width = width;
        mem_signed = sgn; alu_data_res = addr; store_data = sdata;
        @(negedge clk);
        check({tag, "_idle_stall"}, stall, 1'b1);
        check({tag, "_idle_misalign"}, misalign, 1'b0);
        check({tag, "_idle_req"}, mem_req, 1'b0);
        stalls = 1; busy = 0; got_done = 1'b0;
        tick();
        for (int c = 0; c < 40 && !got_done; c++) begin
            @(negedge clk);
            if (stall) begin
                stalls++;
                check({tag, "_busy_req"}, mem_req, 1'b1);
                if (busy == 0) begin
                    check({tag, "_we"}, mem_we, exp_we);
                    check({tag, "_addr"}, mem_addr, exp_addr);
                    check({tag, "_be"}, mem_be, exp_be);
                    check({tag, "_wdata"}, mem_wdata, exp_wdata);
                end
                mem_rdata = rdata;
                mem_ack = (busy == ack_after);
                busy++;
                tick();
                mem_ack = 1'b0;
            end else begin
                got_done = 1'b1;
                check({tag, "_stall_cycles"}, stalls, exp_stall);
                check({tag, "_done_state"}, fsm_state, S_DONE);
                check({tag, "_done_req"}, mem_req, 1'b0);
                exp_v = exp_q.pop_front();
                check({tag, "_result"}, {bus_err, load_data}, exp_v);
                valid = 1'b0; r_datamem = 1'b0; w_datamem = 1'b0;
            end
        end
        check({tag, "_done_seen"}, got_done, 1'b1);
        tick();
        @(negedge clk);
        check({tag, "_back_idle"}, fsm_state, S_IDLE);
        check({tag, "_err_clear"}, bus_err, 1'b0);
        tick();
    endtask

    initial begin
        logic [1:0]  ln;
        logic        sg;
        logic [31:0] rd;
        logic [31:0] ev;
        int          ad;

        #2;
        check("rst_req", mem_req, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_fields", {mem_addr, mem_be, mem_wdata}, 46'h0);
        check("rst_load", load_data, 32'h0);
        check("rst_err", bus_err, 1'b0);
        check("rst_state", fsm_state, S_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Word load, zero-wait memory.
        last_load = 32'hDEAD_BEEF;
        do_access("wload", 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF,
                  10'd4, 4'b1111, 32'h0, 1'b0, 2, {1'b0, last_load});

        // Signed and unsigned byte loads from lane 3.
        last_load = 32'hFFFF_FF80;
        do_access("bload_s", 1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, 32'h80AA_5511,
                  10'd4, 4'b1000, 32'h0, 1'b0, 2, {1'b0, last_load});
        last_load = 32'h0000_0080;
        do_access("bload_u", 1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, 32'h80AA_5511,
                  10'd4, 4'b1000, 32'h0, 1'b0, 2, {1'b0, last_load});

        // Half store, ack on the fourth BUSY cycle; load_data must not move.
        do_access("hstore", 1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h1234_ABCD, 3, 32'h5555_5555,
                  10'd8, 4'b1100, 32'hABCD_ABCD, 1'b1, 5, {1'b0, last_load});

        // Signed half load from the upper lane.
        last_load = 32'hFFFF_8001;
        do_access("hload_s", 1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0, 1, 32'h8001_1234,
                  10'h40, 4'b1100, 32'h0, 1'b0, 3, {1'b0, last_load});

        // Byte store at lane 1.
        do_access("bstore", 1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0205, 32'hCAFE_F05A, 0, 32'h0,
                  10'h81, 4'b0010, 32'h5A5A_5A5A, 1'b1, 2, {1'b0, last_load});

        // Load and store both requested: load wins, no write strobe.
        last_load = 32'h0000_7777;
        do_access("ld_prio", 1'b1, 1'b1, 2'd3, 1'b0, 32'h0000_0030, 32'h1111_1111, 0, 32'h0000_7777,
                  10'd12, 4'b1111, 32'h1111_1111, 1'b0, 2, {1'b0, last_load});

        // Randomised byte loads against the extraction model.
        for (int i = 0; i < 4; i++) begin
            ln = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            rd = $urandom;
            ad = $urandom_range(0, 2);
            ev = model_load(2'd0, sg, ln, rd);
            last_load = ev;
            do_access("rnd_bload", 1'b1, 1'b0, 2'd0, sg, 32'h0000_0100 | 32'(ln), 32'h0, ad, rd,
                      10'h40, 4'b0001 << ln, 32'h0, 1'b0, 2 + ad, {1'b0, ev});
        end

        // Misaligned word load: no request, no stall.
        valid = 1'b1; r_datamem = 1'b1; mem_width = 2'd2; alu_data_res = 32'h06;
        @(negedge clk);
        check("mis_word_flag", misalign, 1'b1);
        check("mis_word_stall", stall, 1'b0);
        tick();
        @(negedge clk);
        check("mis_word_req", mem_req, 1'b0);
        check("mis_word_state", fsm_state, S_IDLE);
        check("mis_word_load", load_data, last_load);
        mem_width = 2'd1; alu_data_res = 32'h03;
        #1;
        check("mis_half_flag", misalign, 1'b1);
        check("mis_half_stall", stall, 1'b0);
        valid = 1'b0; r_datamem = 1'b0;
        #1;
        check("mis_invalid", misalign, 1'b0);
        tick();

        // Ack outside BUSY is ignored.
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        @(negedge clk);
        check("stray_ack_state", fsm_state, S_IDLE);
        check("stray_ack_load", load_data, last_load);
        mem_ack = 1'b0;
        tick();

        // Timeout: no ack for 15 BUSY cycles.
        do_access("timeout", 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, -1, 32'h0,
                  10'h10, 4'b1111, 32'h0, 1'b0, 16, {1'b1, 32'h0});
        last_load = 32'h0;

        // Reload something nonzero, then reset in the middle of BUSY.
        last_load = 32'h0BAD_F00D;
        do_access("pre_rst", 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0050, 32'h0, 0, 32'h0BAD_F00D,
                  10'h14, 4'b1111, 32'h0, 1'b0, 2, {1'b0, last_load});
        valid = 1'b1; r_datamem = 1'b1; mem_width = 2'd2; alu_data_res = 32'h0000_0060;
        tick();
        check("rstb_busy", fsm_state, S_BUSY);
        check("rstb_req", mem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstb_req_drop", mem_req, 1'b0);
        check("rstb_state", fsm_state, S_IDLE);
        check("rstb_load", load_data, 32'h0);
        valid = 1'b0; r_datamem = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("rstb_late_state", fsm_state, S_IDLE);
        check("rstb_late_req", mem_req, 1'b0);
        check("rstb_late_load", load_data, 32'h0);
        mem_ack = 1'b0;
        tick();

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
